// File: rtl/psum_accum_tree.sv
// Partial-sum accumulation tree.
// Joins NUM_IN valid/ready partial-sum channels, adds one word from each
// channel per group, and accumulates a configurable number of groups into one
// widened result. On overflow the result either clamps or wraps. Every output
// comes from a register, or from the state and the hold flags, so no input
// reaches an output combinationally.
module psum_accum_tree #(
  parameter int unsigned NUM_IN   = 3,
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned OWIDTH   = DWIDTH + 4,
  parameter int unsigned RWIDTH   = 4,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RWIDTH-1:0]        cfg_rounds,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DWIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [OWIDTH-1:0]        out_data,
  output logic                     out_ovf,
  input  logic                     out_ready,
  output logic                     busy
);

  // A group sum never exceeds NUM_IN*(2^DWIDTH-1). The accumulator add needs
  // one more bit than the wider of its two operands.
  localparam int unsigned SumW = DWIDTH + $clog2(NUM_IN);
  localparam int unsigned AccW = ((OWIDTH > SumW) ? OWIDTH : SumW) + 1;

  typedef enum logic [1:0] {StCollect, StSum, StOut} state_e;

  state_e                        state_q, state_d;
  logic [NUM_IN-1:0][DWIDTH-1:0] hold_q, hold_d;
  logic [NUM_IN-1:0]             full_q, full_d;
  logic [OWIDTH-1:0]             acc_q, acc_d;
  logic [RWIDTH-1:0]             round_q, round_d;
  logic [RWIDTH-1:0]             rounds_q, rounds_d;
  logic                          ovf_q, ovf_d;

  logic [NUM_IN-1:0]             fire;
  logic [SumW-1:0]               grp_sum;
  logic [AccW-1:0]               acc_full;
  logic                          acc_over;
  logic [RWIDTH-1:0]             last_round;
  logic                          final_round;

  assign fire = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StCollect;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; SUM follows the edge that completes the group
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (&full_d) state_d = StSum;
      StSum:     state_d = final_round ? StOut : StCollect;
      StOut:     if (out_ready) state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  // Handshake outputs decoded from the state and the hold flags only
  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    unique case (state_q)
      StCollect: in_ready = ~full_q;
      StSum:     ;
      StOut:     out_valid = 1'b1;
      default:   ;
    endcase
  end

  assign out_data = acc_q;
  assign out_ovf  = ovf_q;
  assign busy     = (|full_q) || (state_q != StCollect);

  // Group adder over the held words
  always_comb begin
    grp_sum = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      grp_sum = grp_sum + SumW'(hold_q[i]);
    end
  end

  // Round 0 ignores the old accumulator, so results never leak into each other
  assign acc_full    = ((round_q == '0) ? '0 : AccW'(acc_q)) + AccW'(grp_sum);
  assign acc_over    = acc_full > AccW'({OWIDTH{1'b1}});
  // A latched round count of 0 behaves as 1
  assign last_round  = (rounds_q == '0) ? '0 : rounds_q - 1'b1;
  assign final_round = (round_q == last_round);

  // Datapath next state: capture, accumulate, and release the result
  always_comb begin
    hold_d   = hold_q;
    full_d   = full_q;
    acc_d    = acc_q;
    round_d  = round_q;
    rounds_d = rounds_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StCollect: begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (fire[i]) hold_d[i] = in_data[i*DWIDTH +: DWIDTH];
        end
        full_d = full_q | fire;
        // The round count is frozen at the first capture of a new result
        if ((round_q == '0) && (full_q == '0) && (fire != '0)) rounds_d = cfg_rounds;
      end
      StSum: begin
        full_d = '0;
        if (acc_over) begin
          ovf_d = 1'b1;
          acc_d = SATURATE ? '1 : acc_full[OWIDTH-1:0];
        end else begin
          acc_d = acc_full[OWIDTH-1:0];
        end
        if (!final_round) round_d = round_q + 1'b1;
      end
      StOut: begin
        if (out_ready) begin
          round_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset drops any partial group and any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q   <= '0;
      full_q   <= '0;
      acc_q    <= '0;
      round_q  <= '0;
      rounds_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      full_q   <= full_d;
      acc_q    <= acc_d;
      round_q  <= round_d;
      rounds_q <= rounds_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_psum_accum_tree.sv
// Randomized bench for psum_accum_tree. Three instances share one input
// stream: a 12-bit saturating result, an 8-bit saturating result and an 8-bit
// wrapping result. Expected results come from plain integer sums per result.
module tb_psum_accum_tree;

  localparam int unsigned NUM_IN = 3;
  localparam int unsigned DWIDTH = 8;
  localparam int unsigned RWIDTH = 4;
  localparam int unsigned OWA    = 12;
  localparam int unsigned OWB    = 8;
  localparam int unsigned MaxA   = (1 << OWA) - 1;
  localparam int unsigned MaxB   = (1 << OWB) - 1;

  typedef struct {
    int unsigned cap;
    logic [31:0] da, db, dc;
    logic        oa, ob, oc;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [RWIDTH-1:0]        cfg_rounds;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*DWIDTH-1:0] in_data;
  logic                     out_ready;

  logic [NUM_IN-1:0] in_ready_a, in_ready_b, in_ready_c;
  logic              out_valid_a, out_valid_b, out_valid_c;
  logic [OWA-1:0]    out_data_a;
  logic [OWB-1:0]    out_data_b, out_data_c;
  logic              out_ovf_a, out_ovf_b, out_ovf_c;
  logic              busy_a, busy_b, busy_c;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last_cap = 0;
  int          hold_off = 0;
  exp_t        q[$];
  logic [DWIDTH-1:0] grp [16][NUM_IN];

  psum_accum_tree #(.NUM_IN(NUM_IN), .DWIDTH(DWIDTH), .OWIDTH(OWA), .RWIDTH(RWIDTH),
                    .SATURATE(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .cfg_rounds(cfg_rounds), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready_a), .out_valid(out_valid_a),
    .out_data(out_data_a), .out_ovf(out_ovf_a), .out_ready(out_ready), .busy(busy_a)
  );

  psum_accum_tree #(.NUM_IN(NUM_IN), .DWIDTH(DWIDTH), .OWIDTH(OWB), .RWIDTH(RWIDTH),
                    .SATURATE(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .cfg_rounds(cfg_rounds), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready_b), .out_valid(out_valid_b),
    .out_data(out_data_b), .out_ovf(out_ovf_b), .out_ready(out_ready), .busy(busy_b)
  );

  psum_accum_tree #(.NUM_IN(NUM_IN), .DWIDTH(DWIDTH), .OWIDTH(OWB), .RWIDTH(RWIDTH),
                    .SATURATE(1'b0)) u_dut_c (
    .clk(clk), .reset(reset), .cfg_rounds(cfg_rounds), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready_c), .out_valid(out_valid_c),
    .out_data(out_data_c), .out_ovf(out_ovf_c), .out_ready(out_ready), .busy(busy_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Present group g on the channels in mask with a random 0..3 cycle stagger per
  // channel, holding each valid until it is taken. Returns just before the
  // edge that takes the last word. cfg is shown only until the first word of
  // group 0 is taken; afterwards cfg_rounds is scrambled.
  task automatic drive_group(input int g, input logic [NUM_IN-1:0] mask, input int cfg);
    logic [NUM_IN-1:0] done;
    logic [NUM_IN-1:0] fire;
    int                st[NUM_IN];
    int                k;
    bit                fired_any;
    done      = ~mask;
    k         = 0;
    fired_any = 1'b0;
    foreach (st[i]) st[i] = int'($urandom_range(0, 3));
    while ((done != '1) && (k < 300)) begin
      @(negedge clk);
      if ((g == 0) && !fired_any) cfg_rounds = RWIDTH'(cfg);
      else                        cfg_rounds = RWIDTH'($urandom);
      for (int i = 0; i < NUM_IN; i++) begin
        in_valid[i] = !done[i] && (k >= st[i]);
        in_data[i*DWIDTH +: DWIDTH] = in_valid[i] ? grp[g][i] : DWIDTH'($urandom);
        if (done[i] && mask[i]) check("rdy_low_after_cap", 32'(in_ready_a[i]), 32'd0);
      end
      fire = in_valid & in_ready_a;
      if (fire != '0) begin
        fired_any = 1'b1;
        last_cap  = cyc;
      end
      done = done | fire;
      k++;
    end
    if (done != '1) check("drv_timeout", 32'(done), 32'((1 << NUM_IN) - 1));
  endtask

  // One complete result; the expectation is the plain integer total of all words
  task automatic run_result(input int cfg, input bit rnd);
    int          n;
    int unsigned total;
    exp_t        e;
    n     = (cfg == 0) ? 1 : cfg;
    total = 0;
    for (int g = 0; g < n; g++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (rnd) grp[g][i] = DWIDTH'($urandom);
        total += int'(grp[g][i]);
      end
    end
    for (int g = 0; g < n; g++) drive_group(g, '1, cfg);
    e.cap = last_cap;
    e.da  = (total > MaxA) ? MaxA : total;
    e.oa  = (total > MaxA);
    e.db  = (total > MaxB) ? MaxB : total;
    e.ob  = (total > MaxB);
    e.dc  = total % (MaxB + 1);
    e.oc  = (total > MaxB);
    q.push_back(e);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((q.size() != 0) && (k < 500)) begin
      @(negedge clk);
      in_valid = '0;
      k++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  // Result monitor: the model decides when a result must be on the port
  initial begin : monitor
    bit   ev;
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      ev = (q.size() > 0) && (cyc >= q[0].cap + 2);
      if (ev && (hold_off > 0)) begin
        out_ready = 1'b0;
        hold_off--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (reset !== 1'b1) begin
        check("out_valid_a", 32'(out_valid_a), 32'(ev));
        check("out_valid_b", 32'(out_valid_b), 32'(ev));
        check("out_valid_c", 32'(out_valid_c), 32'(ev));
        if (ev) begin
          e = q[0];
          check("out_data_a", 32'(out_data_a), e.da);
          check("out_ovf_a", 32'(out_ovf_a), 32'(e.oa));
          check("out_data_b_sat", 32'(out_data_b), e.db);
          check("out_ovf_b", 32'(out_ovf_b), 32'(e.ob));
          check("out_data_c_wrap", 32'(out_data_c), e.dc);
          check("out_ovf_c", 32'(out_ovf_c), 32'(e.oc));
          check("in_ready_in_out", 32'({in_ready_a, in_ready_b, in_ready_c}), 32'd0);
          check("busy_in_out", 32'(busy_a), 32'd1);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset      = 1'b1;
    cfg_rounds = '0;
    in_valid   = '0;
    in_data    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready_a), 32'h7);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_out_data", 32'(out_data_a), 32'd0);
    check("rst_out_ovf", 32'(out_ovf_a), 32'd0);

    // 5+7+9 in one group
    grp[0][0] = 8'd5; grp[0][1] = 8'd7; grp[0][2] = 8'd9;
    run_result(1, 1'b0);

    // Four staggered groups of {10,20,30}
    for (int g = 0; g < 4; g++) begin
      grp[g][0] = 8'd10; grp[g][1] = 8'd20; grp[g][2] = 8'd30;
    end
    run_result(4, 1'b0);

    // Two groups of all-255 overflow the 8-bit instances
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < NUM_IN; i++) grp[g][i] = 8'd255;
    end
    run_result(2, 1'b0);

    // Held-off acceptance while the next result is already pending at the inputs
    wait_drain();
    hold_off = 5;
    run_result(2, 1'b1);
    run_result(3, 1'b1);

    // A round count of 0 acts as 1
    run_result(0, 1'b1);

    for (int r = 0; r < 40; r++) run_result(int'($urandom_range(0, 6)), 1'b1);

    // Reset with two of three channels held in round 2
    wait_drain();
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < NUM_IN; i++) grp[g][i] = DWIDTH'($urandom);
    end
    drive_group(0, '1, 3);
    drive_group(1, '1, 3);
    drive_group(2, 3'b011, 3);
    @(negedge clk);
    in_valid = '0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready_a), 32'h7);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid_a), 32'd0);
    check("mid_rst_acc", 32'(out_data_a), 32'd0);

    grp[0][0] = 8'd1; grp[0][1] = 8'd2; grp[0][2] = 8'd3;
    run_result(1, 1'b0);
    run_result(5, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);
    check("end_busy", 32'(busy_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
